// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main control unit:
// opcodes, state codes, ALU-op / PC-source selects and the control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_EXEC   = 4'd6;
    localparam state_t S_ALUWB  = 4'd7;
    localparam state_t S_ADDIEX = 4'd8;
    localparam state_t S_ORIEX  = 4'd9;
    localparam state_t S_IMMWB  = 4'd10;
    localparam state_t S_BEQ    = 4'd11;
    localparam state_t S_BNE    = 4'd12;
    localparam state_t S_JUMP   = 4'd13;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       retire;
    } ctrl_t;

    function automatic logic is_ext_op(input logic [5:0] op);
        return (op == OP_BNE) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control-word decode (ungated Moore outputs).
// Unused state codes decode to an all-zero word.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.irwrite = 1'b1;
                o_ctrl.pcwrite = 1'b1;
                o_ctrl.alusrcb = SRCB_FOUR;
            end
            S_DECODE: begin
                o_ctrl.alusrcb = SRCB_IMMSH;
            end
            S_MEMADR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.retire   = 1'b1;
            end
            // retire here is qualified by ready in the top level
            S_MEMWR: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.memwrite = 1'b1;
                o_ctrl.retire   = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.regdst   = 1'b1;
                o_ctrl.retire   = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_ORIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
                o_ctrl.zeroext = 1'b1;
                o_ctrl.aluop   = ALUOP_OR;
            end
            S_IMMWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.retire   = 1'b1;
            end
            S_BEQ: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_SUB;
                o_ctrl.branch  = 1'b1;
                o_ctrl.pcsrc   = PCSRC_ALUOUT;
                o_ctrl.retire  = 1'b1;
            end
            S_BNE: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.aluop     = ALUOP_SUB;
                o_ctrl.branch_ne = 1'b1;
                o_ctrl.pcsrc     = PCSRC_ALUOUT;
                o_ctrl.retire    = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pcwrite = 1'b1;
                o_ctrl.pcsrc   = PCSRC_JUMP;
                o_ctrl.retire  = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS-subset main control: state register, next-state
// logic, memory-ready gating, illegal-opcode and retire pulses.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int P_MEM_HS = 1,
    parameter int P_EN_EXT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_op,
    input  logic       i_mem_ready,
    output logic       o_iord,
    output logic       o_irwrite,
    output logic       o_pcwrite,
    output logic       o_branch,
    output logic       o_branch_ne,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic       o_zeroext,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic [1:0] o_pcsrc,
    output logic [1:0] o_aluop,
    output logic       o_illegal,
    output logic       o_retire
);

    localparam logic L_EXT = (P_EN_EXT != 0);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_ready;
    logic   w_illegal;
    logic   w_fetch_gate;
    logic   w_wr_gate;

    assign w_ready = (P_MEM_HS == 0) ? 1'b1 : i_mem_ready;

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_LW,
                    OP_SW:    w_next = S_MEMADR;
                    OP_RTYPE: w_next = S_EXEC;
                    OP_BEQ:   w_next = S_BEQ;
                    OP_BNE:   w_next = L_EXT ? S_BNE : S_FETCH;
                    OP_ADDI:  w_next = S_ADDIEX;
                    OP_ORI:   w_next = L_EXT ? S_ORIEX : S_FETCH;
                    OP_J:     w_next = S_JUMP;
                    default:  w_next = S_FETCH;
                endcase
                w_illegal = (w_next == S_FETCH);
            end
            S_MEMADR: w_next = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX,
            S_ORIEX:  w_next = S_IMMWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    mc_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // JUMP also raises pcwrite, so gating applies only in FETCH
    assign w_fetch_gate = (r_state != S_FETCH) || w_ready;
    assign w_wr_gate    = (r_state != S_MEMWR) || w_ready;

    assign o_iord      = w_ctrl.iord;
    assign o_irwrite   = w_ctrl.irwrite & w_fetch_gate;
    assign o_pcwrite   = w_ctrl.pcwrite & w_fetch_gate;
    assign o_branch    = w_ctrl.branch;
    assign o_branch_ne = w_ctrl.branch_ne;
    assign o_alusrca   = w_ctrl.alusrca;
    assign o_alusrcb   = w_ctrl.alusrcb;
    assign o_zeroext   = w_ctrl.zeroext;
    assign o_regdst    = w_ctrl.regdst;
    assign o_memtoreg  = w_ctrl.memtoreg;
    assign o_regwrite  = w_ctrl.regwrite;
    assign o_memwrite  = w_ctrl.memwrite;
    assign o_pcsrc     = w_ctrl.pcsrc;
    assign o_aluop     = w_ctrl.aluop;
    assign o_illegal   = w_illegal;
    assign o_retire    = w_ctrl.retire & w_wr_gate;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Table-driven bench for mc_main_ctrl across three parameter sets;
// expected control words are queued on drive and checked mid-cycle.
module tb_mc_main_ctrl;

    localparam logic [5:0] T_R   = 6'b000000;
    localparam logic [5:0] T_J   = 6'b000010;
    localparam logic [5:0] T_BEQ = 6'b000100;
    localparam logic [5:0] T_BNE = 6'b000101;
    localparam logic [5:0] T_ADI = 6'b001000;
    localparam logic [5:0] T_ORI = 6'b001101;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [5:0] T_BAD = 6'b111111;

    function automatic logic [18:0] cw(
        input logic iord, irw, pcw, br, bne, asa,
        input logic [1:0] asb,
        input logic zx, rd, m2r, rw, mw,
        input logic [1:0] pcs, aop,
        input logic ill, ret);
        return {iord, irw, pcw, br, bne, asa, asb, zx, rd, m2r, rw, mw,
                pcs, aop, ill, ret};
    endfunction

    localparam logic [18:0] E_FETCH = cw(0,1,1,0,0,0,2'b01,0,0,0,0,0,2'b00,2'b00,0,0);
    localparam logic [18:0] E_FSTL  = cw(0,0,0,0,0,0,2'b01,0,0,0,0,0,2'b00,2'b00,0,0);
    localparam logic [18:0] E_DEC   = cw(0,0,0,0,0,0,2'b11,0,0,0,0,0,2'b00,2'b00,0,0);
    localparam logic [18:0] E_DILL  = cw(0,0,0,0,0,0,2'b11,0,0,0,0,0,2'b00,2'b00,1,0);
    localparam logic [18:0] E_MADR  = cw(0,0,0,0,0,1,2'b10,0,0,0,0,0,2'b00,2'b00,0,0);
    localparam logic [18:0] E_MRD   = cw(1,0,0,0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,0);
    localparam logic [18:0] E_MWB   = cw(0,0,0,0,0,0,2'b00,0,0,1,1,0,2'b00,2'b00,0,1);
    localparam logic [18:0] E_MWR   = cw(1,0,0,0,0,0,2'b00,0,0,0,0,1,2'b00,2'b00,0,0);
    localparam logic [18:0] E_MWRR  = cw(1,0,0,0,0,0,2'b00,0,0,0,0,1,2'b00,2'b00,0,1);
    localparam logic [18:0] E_EXEC  = cw(0,0,0,0,0,1,2'b00,0,0,0,0,0,2'b00,2'b10,0,0);
    localparam logic [18:0] E_AWB   = cw(0,0,0,0,0,0,2'b00,0,1,0,1,0,2'b00,2'b00,0,1);
    localparam logic [18:0] E_ADDI  = cw(0,0,0,0,0,1,2'b10,0,0,0,0,0,2'b00,2'b00,0,0);
    localparam logic [18:0] E_ORI   = cw(0,0,0,0,0,1,2'b10,1,0,0,0,0,2'b00,2'b11,0,0);
    localparam logic [18:0] E_IWB   = cw(0,0,0,0,0,0,2'b00,0,0,0,1,0,2'b00,2'b00,0,1);
    localparam logic [18:0] E_BEQ   = cw(0,0,0,1,0,1,2'b00,0,0,0,0,0,2'b01,2'b01,0,1);
    localparam logic [18:0] E_BNE   = cw(0,0,0,0,1,1,2'b00,0,0,0,0,0,2'b01,2'b01,0,1);
    localparam logic [18:0] E_JMP   = cw(0,0,1,0,0,0,2'b00,0,0,0,0,0,2'b10,2'b00,0,1);

    localparam logic [18:0] M_RST   = 19'h7FFFF & ~(19'h3 << 16);
    localparam int          T_WDOG  = 200;

    typedef struct {
        string       tag;
        int          sel;
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [18:0] exp;
        bit          chk;
    } vec_t;

    typedef struct {
        string       tag;
        int          sel;
        logic [18:0] exp;
        int          idx;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [18:0] act [3];
    logic        was_rst;
    bit          done;

    vec_t vq[$];
    sb_t  sb[$];
    int   n_vec;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       iord, irw, pcw, br, bne, asa, zx, rd, m2r, rw, mw;
        logic       ill, ret;
        logic [1:0] asb, pcs, aop;
        mc_main_ctrl #(
            .P_MEM_HS ((g == 2) ? 0 : 1),
            .P_EN_EXT ((g == 1) ? 0 : 1)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_op        (op),
            .i_mem_ready (rdy),
            .o_iord      (iord),
            .o_irwrite   (irw),
            .o_pcwrite   (pcw),
            .o_branch    (br),
            .o_branch_ne (bne),
            .o_alusrca   (asa),
            .o_alusrcb   (asb),
            .o_zeroext   (zx),
            .o_regdst    (rd),
            .o_memtoreg  (m2r),
            .o_regwrite  (rw),
            .o_memwrite  (mw),
            .o_pcsrc     (pcs),
            .o_aluop     (aop),
            .o_illegal   (ill),
            .o_retire    (ret)
        );
        assign act[g] = {iord, irw, pcw, br, bne, asa, asb, zx, rd, m2r,
                         rw, mw, pcs, aop, ill, ret};
    end

    task automatic add(input string tag, input int sel, input logic r,
                       input logic [5:0] o, input logic rd,
                       input logic [18:0] e, input bit c = 1'b1);
        vec_t v;
        v.tag = tag; v.sel = sel; v.rst = r; v.op = o;
        v.rdy = rd; v.exp = e; v.chk = c;
        vq.push_back(v);
    endtask

    always @(posedge clk) was_rst <= rst;

    always @(negedge clk) begin
        if (was_rst === 1'b1) begin
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if ((act[g] & M_RST) !== (E_FETCH & M_RST)) begin
                    n_bad++;
                    $display("FAIL reset-state dut%0d: got %b want %b",
                             g, act[g] & M_RST, E_FETCH & M_RST);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t s;
            s = sb.pop_front();
            n_vec++;
            if (act[s.sel] !== s.exp) begin
                n_bad++;
                $display("FAIL %s #%0d dut%0d: got %b want %b",
                         s.tag, s.idx, s.sel, act[s.sel], s.exp);
            end
        end
    end

    initial begin
        done = 1'b0;
        repeat (T_WDOG) @(posedge clk);
        if (!done) begin
            $display("FAIL timeout: bench did not finish in %0d cycles",
                     T_WDOG);
            $finish;
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        op  = T_R;
        rdy = 1'b1;

        repeat (3) add("rst", 0, 1, T_R, 1, E_FETCH);
        add("lw_f",   0, 0, T_LW, 1, E_FETCH);
        add("lw_d",   0, 0, T_LW, 1, E_DEC);
        add("lw_ma",  0, 0, T_LW, 1, E_MADR);
        add("lw_rd",  0, 0, T_LW, 1, E_MRD);
        add("lw_wb",  0, 0, T_LW, 1, E_MWB);

        add("sw_f",   0, 0, T_SW, 1, E_FETCH);
        add("sw_d",   0, 0, T_SW, 1, E_DEC);
        add("sw_ma",  0, 0, T_SW, 1, E_MADR);
        repeat (3) add("sw_stl", 0, 0, T_SW, 0, E_MWR);
        add("sw_ret", 0, 0, T_SW, 1, E_MWRR);

        add("r_fstl", 0, 0, T_R, 0, E_FSTL);
        add("r_f",    0, 0, T_R, 1, E_FETCH);
        add("r_d",    0, 0, T_R, 0, E_DEC);
        add("r_ex",   0, 0, T_R, 1, E_EXEC);
        add("r_wb",   0, 0, T_R, 0, E_AWB);

        add("ad_f",   0, 0, T_ADI, 1, E_FETCH);
        add("ad_d",   0, 0, T_ADI, 1, E_DEC);
        add("ad_ex",  0, 0, T_ADI, 0, E_ADDI);
        add("ad_wb",  0, 0, T_ADI, 1, E_IWB);

        add("or_f",   0, 0, T_ORI, 1, E_FETCH);
        add("or_d",   0, 0, T_ORI, 1, E_DEC);
        add("or_ex",  0, 0, T_ORI, 1, E_ORI);
        add("or_wb",  0, 0, T_ORI, 1, E_IWB);

        add("beq_f",  0, 0, T_BEQ, 1, E_FETCH);
        add("beq_d",  0, 0, T_BEQ, 1, E_DEC);
        add("beq_x",  0, 0, T_BEQ, 1, E_BEQ);
        add("bne_f",  0, 0, T_BNE, 1, E_FETCH);
        add("bne_d",  0, 0, T_BNE, 1, E_DEC);
        add("bne_x",  0, 0, T_BNE, 1, E_BNE);
        add("j_f",    0, 0, T_J, 1, E_FETCH);
        add("j_d",    0, 0, T_J, 1, E_DEC);
        add("j_x",    0, 0, T_J, 1, E_JMP);
        add("ill_f",  0, 0, T_BAD, 1, E_FETCH);
        add("ill_d",  0, 0, T_BAD, 1, E_DILL);
        add("ill_nx", 0, 0, T_BAD, 0, E_FSTL);

        add("x_rst",  1, 1, T_R, 1, '0, 1'b0);
        add("x_f",    1, 0, T_BNE, 1, E_FETCH);
        add("x_bne",  1, 0, T_BNE, 1, E_DILL);
        add("x_f2",   1, 0, T_ORI, 1, E_FETCH);
        add("x_ori",  1, 0, T_ORI, 1, E_DILL);
        add("x_f3",   1, 0, T_LW, 1, E_FETCH);
        add("x_lw",   1, 0, T_LW, 1, E_DEC);

        add("h_rst",  2, 1, T_LW, 0, '0, 1'b0);
        add("h_f",    2, 0, T_LW, 0, E_FETCH);
        add("h_d",    2, 0, T_LW, 0, E_DEC);
        add("h_ma",   2, 0, T_LW, 0, E_MADR);
        add("h_rd",   2, 0, T_LW, 0, E_MRD);
        add("h_wb",   2, 0, T_LW, 0, E_MWB);
        add("h_swf",  2, 0, T_SW, 0, E_FETCH);
        add("h_swd",  2, 0, T_SW, 0, E_DEC);
        add("h_swma", 2, 0, T_SW, 0, E_MADR);
        add("h_swwr", 2, 0, T_SW, 0, E_MWRR);
        add("h_nx",   2, 0, T_SW, 0, E_FETCH);

        add("m_rst",  0, 1, T_LW, 1, '0, 1'b0);
        add("m_f",    0, 0, T_LW, 1, E_FETCH);
        add("m_d",    0, 0, T_LW, 1, E_DEC);
        add("m_ma",   0, 0, T_LW, 1, E_MADR);
        add("m_rdrs", 0, 1, T_LW, 1, E_MRD);
        add("m_f2",   0, 0, T_SW, 1, E_FETCH);
        add("w_d",    0, 0, T_SW, 1, E_DEC);
        add("w_ma",   0, 0, T_SW, 1, E_MADR);
        add("w_wrrs", 0, 1, T_SW, 0, E_MWR);
        add("w_f",    0, 0, T_SW, 1, E_FETCH);
        add("w_d2",   0, 0, T_J, 1, E_DEC);

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst;
            op  = vq[i].op;
            rdy = vq[i].rdy;
            if (vq[i].chk) begin
                sb_t s;
                s.tag = vq[i].tag; s.sel = vq[i].sel;
                s.exp = vq[i].exp; s.idx = i;
                sb.push_back(s);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0)
            $display("FAIL: %0d miscompares", n_bad);
        else
            $display("PASS");
        $finish;
    end

endmodule
